// File: rtl/wb_burst_mem_slave.sv
// wb_burst_mem_slave: Wishbone burst responder backed by an internal word array.
// Returns one registered ack per beat after a fixed request-to-data latency.
module wb_burst_mem_slave #(
  parameter int ADDR_LEN   = 32,
  parameter int DATA_LEN   = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_LEN-1:0] wb_adr_i,
  input  logic [9:0]          wb_bl_i,
  input  logic                wb_bry_i,
  input  logic [DATA_LEN-1:0] wb_dat_i,
  output logic                wb_ack_o,
  output logic [DATA_LEN-1:0] wb_dat_o,
  output logic                wb_err_o
);
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic [9:0]            beats_q, beats_d;
  logic [7:0]            lat_q, lat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_LEN-1:0]   dat_q, dat_d;
  logic [DATA_LEN-1:0]   mem [2**DEPTH_LOG2];
  logic                  req, oor, beat, adr_unused;
  assign req        = wb_cyc_i & wb_stb_i;
  assign oor        = |wb_adr_i[ADDR_LEN-1:DEPTH_LOG2+2];
  assign beat       = (state_q == BURST) & wb_cyc_i & wb_bry_i;
  assign adr_unused = ^wb_adr_i[1:0];
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    we_d    = we_q;
    beats_d = beats_q;
    lat_d   = lat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      IDLE: if (req) begin
        idx_d   = wb_adr_i[DEPTH_LOG2+1:2];
        we_d    = wb_we_i;
        beats_d = (wb_bl_i == 10'd0) ? 10'd1 : wb_bl_i;
        lat_d   = 8'(RD_LATENCY - 1);
        err_d   = oor;
        state_d = oor ? DONE : ((RD_LATENCY == 1) ? BURST : WAIT);
      end
      WAIT: begin
        if (!wb_cyc_i) state_d = IDLE;
        else if (lat_q == 8'd0) state_d = BURST;
        else lat_d = lat_q - 8'd1;
      end
      BURST: begin
        if (!wb_cyc_i) state_d = IDLE;
        else if (wb_bry_i) begin
          ack_d   = 1'b1;
          idx_d   = idx_q + 1'b1;
          beats_d = beats_q - 10'd1;
          dat_d   = we_q ? dat_q : mem[idx_q];
          state_d = (beats_q == 10'd1) ? DONE : BURST;
        end
      end
      DONE: if (!wb_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      we_q    <= 1'b0;
      beats_q <= '0;
      lat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      beats_q <= beats_d;
      lat_q   <= lat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end
  // Array is never cleared; a reset edge blocks the write of that cycle.
  always_ff @(posedge clk) begin
    if (rstn && beat && we_q) mem[idx_q] <= wb_dat_i;
  end
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
endmodule
